// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp patterns for the two-approach intersection.
// Lamp vectors are {red, yellow, green}, exactly one bit set.
package traffic_pkg;

  typedef enum logic [2:0] {
    AR_MAIN = 3'd0,
    MAIN_G  = 3'd1,
    MAIN_Y  = 3'd2,
    AR_SIDE = 3'd3,
    SIDE_G  = 3'd4,
    SIDE_Y  = 3'd5
  } ph_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  // Any phase not owned by an approach shows red on that approach.
  function automatic logic [2:0] main_lamp(input ph_t ph);
    case (ph)
      MAIN_G:  main_lamp = L_GRN;
      MAIN_Y:  main_lamp = L_YEL;
      default: main_lamp = L_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input ph_t ph);
    case (ph)
      SIDE_G:  side_lamp = L_GRN;
      SIDE_Y:  side_lamp = L_YEL;
      default: side_lamp = L_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; a load takes priority over counting.
module phase_timer #(
  parameter int CNT_W   = 5,
  parameter int RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Main/side intersection sequencer: main rests on green, side or pedestrian
// requests run a yellow/all-red protected side cycle, emergency cuts side green short.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 5,
  parameter int MAIN_MIN = 8,
  parameter int SIDE_T   = 6,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emg,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] MAIN_LD = CNT_W'(MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] SIDE_LD = CNT_W'(SIDE_T - 1);
  localparam logic [CNT_W-1:0] YEL_LD  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LD   = CNT_W'(ALLRED_T - 1);

  ph_t              state_q, state_d;
  logic             side_pend_q, side_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             walk_en_q, walk_en_d;
  logic [2:0]       main_rgy_q, main_rgy_d;
  logic [2:0]       side_rgy_q, side_rgy_d;
  logic             walk_q, walk_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             enter_side_g;

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(ALLRED_T - 1)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .value(tmr_val),
    .zero (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      AR_MAIN: if (tmr_zero) begin
        state_d = MAIN_G; tmr_load = 1'b1; tmr_val = MAIN_LD;
      end
      // Main green holds with the timer parked at zero until a request arrives.
      MAIN_G: if (tmr_zero && (side_pend_q || ped_pend_q) && !emg) begin
        state_d = MAIN_Y; tmr_load = 1'b1; tmr_val = YEL_LD;
      end
      MAIN_Y: if (tmr_zero) begin
        state_d = AR_SIDE; tmr_load = 1'b1; tmr_val = AR_LD;
      end
      AR_SIDE: if (tmr_zero) begin
        state_d = SIDE_G; tmr_load = 1'b1; tmr_val = SIDE_LD;
      end
      SIDE_G: if (tmr_zero || emg) begin
        state_d = SIDE_Y; tmr_load = 1'b1; tmr_val = YEL_LD;
      end
      SIDE_Y: if (tmr_zero) begin
        state_d = AR_MAIN; tmr_load = 1'b1; tmr_val = AR_LD;
      end
      default: begin
        state_d = AR_MAIN; tmr_load = 1'b1; tmr_val = AR_LD;
      end
    endcase
  end

  // A request arriving on the SIDE_G entry edge is served by that phase, so clear wins.
  always_comb begin
    enter_side_g = (state_d == SIDE_G) && (state_q != SIDE_G);
    side_pend_d  = (side_pend_q || side_req) && !enter_side_g;
    ped_pend_d   = (ped_pend_q || ped_req) && !enter_side_g;
    walk_en_d    = enter_side_g ? (ped_pend_q || ped_req) : walk_en_q;
    main_rgy_d   = main_lamp(state_d);
    side_rgy_d   = side_lamp(state_d);
    walk_d       = walk_en_d && (state_d == SIDE_G);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= AR_MAIN;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      walk_en_q   <= 1'b0;
      main_rgy_q  <= L_RED;
      side_rgy_q  <= L_RED;
      walk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      walk_en_q   <= walk_en_d;
      main_rgy_q  <= main_rgy_d;
      side_rgy_q  <= side_rgy_d;
      walk_q      <= walk_d;
    end
  end

  assign main_rgy = main_rgy_q;
  assign side_rgy = side_rgy_q;
  assign walk     = walk_q;
  assign phase    = state_q;

endmodule
